// File: rtl/vdec1_fwd.sv
// vdec1_fwd: forward add-compare-select stage of the rate-1/3, K=9 Viterbi
// decoder (256 states). Each accepted 3-LLR symbol runs one trellis step as
// 8 words of 32 states. Every word's 32 survivor decisions are written to the
// path-traceback RAM at {step, word}.
//
// Optional build macro: VDEC1_TAIL_FORCE_EN. When it is defined, tail steps
// (step >= NS) pin states with s[0]=1 to the floor metric and write their
// decisions as 0.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle start pulse, ignored while busy
//   codeblk_size    info bits N (0..29, larger values clamp to 29)
//   busy, done      block in progress / one-cycle completion pulse
//   sym_valid/ready symbol handshake; sym_llr = {L2,L1,L0}
//   pt_we/addr/din  traceback RAM write port, addr = {step[5:0], word[2:0]}

// One ACS lane: one state, both candidate predecessors.
module vdec1_acs_lane #(
  parameter int LLR_W = 6,
  parameter int PM_W  = 14
) (
  input  logic [7:0]              s,
  input  logic [3*LLR_W-1:0]      llr,
  input  logic signed [PM_W-1:0]  pm0,
  input  logic signed [PM_W-1:0]  pm1,
  output logic signed [PM_W-1:0]  pm_new,
  output logic                    dec
);
  // Generators G2,G1,G0 = 711,663,557 octal.
  localparam logic [26:0] GPOLY = {9'o711, 9'o663, 9'o557};

  // x[8] is the newest bit u. x[8-j] is the bit j steps earlier, which is
  // s[j] for j<8 and the decision bit d for j=8.
  function automatic logic signed [LLR_W+1:0] bm(input logic d, input logic [7:0] st,
                                                 input logic [3*LLR_W-1:0] l);
    logic [8:0] x;
    logic [8:0] g;
    logic signed [LLR_W+1:0] acc, lk;
    x[8] = st[0];
    for (int j = 1; j < 8; j++) x[8-j] = st[j];
    x[0] = d;
    acc = '0;
    for (int k = 0; k < 3; k++) begin
      g  = GPOLY[9*k +: 9];
      lk = {{2{l[LLR_W*k+LLR_W-1]}}, l[LLR_W*k +: LLR_W]};
      if (^(g & x)) acc = acc - lk;
      else          acc = acc + lk;
    end
    return acc;
  endfunction

  logic signed [LLR_W+1:0] bm0, bm1;
  logic signed [PM_W-1:0]  m0, m1;

  assign bm0 = bm(1'b0, s, llr);
  assign bm1 = bm(1'b1, s, llr);
  assign m0  = pm0 + {{(PM_W-LLR_W-2){bm0[LLR_W+1]}}, bm0};
  assign m1  = pm1 + {{(PM_W-LLR_W-2){bm1[LLR_W+1]}}, bm1};
  // Ties keep the d=0 predecessor.
  assign dec    = (m1 > m0);
  assign pm_new = dec ? m1 : m0;
endmodule

module vdec1_fwd #(
  parameter int LLR_W = 6,
  parameter int PM_W  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [5:0]         codeblk_size,
  output logic               busy,
  output logic               done,
  input  logic               sym_valid,
  output logic               sym_ready,
  input  logic [3*LLR_W-1:0] sym_llr,
  output logic               pt_we,
  output logic [8:0]         pt_addr,
  output logic [31:0]        pt_din
);
  localparam int NUM_LANES = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACS  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  // -2^(PM_W-2): the starting metric for every state other than 0.
  localparam logic signed [PM_W-1:0] PM_NEG = {2'b11, {(PM_W-2){1'b0}}};

  logic [1:0]           state;
  logic [5:0]           ns_r, step;
  logic [2:0]           word;
  logic [3*LLR_W-1:0]   llr_r;
  logic                 sel;  // 0: read pm_a / write pm_b, 1: the reverse

  logic signed [PM_W-1:0] pm_a [256];
  logic signed [PM_W-1:0] pm_b [256];

  logic [NUM_LANES-1:0][PM_W-1:0] lane_pm;
  logic [NUM_LANES-1:0]           lane_dec;

`ifdef VDEC1_TAIL_FORCE_EN
  logic tail;
  assign tail = (step >= ns_r);
`endif

  assign sym_ready = (state == S_WAIT);

  for (genvar L = 0; L < NUM_LANES; L++) begin : g_lane
    localparam logic [4:0] LB = 5'(L);
    logic [7:0]             s, i0, i1;
    logic signed [PM_W-1:0] pm0, pm1, pm_raw;
    logic                   dec_raw;

    assign s   = {word, LB};
    assign i0  = {1'b0, word, LB[4:1]};
    assign i1  = {1'b1, word, LB[4:1]};
    assign pm0 = sel ? pm_b[i0] : pm_a[i0];
    assign pm1 = sel ? pm_b[i1] : pm_a[i1];

    vdec1_acs_lane #(.LLR_W(LLR_W), .PM_W(PM_W)) u_lane (
      .s      (s),
      .llr    (llr_r),
      .pm0    (pm0),
      .pm1    (pm1),
      .pm_new (pm_raw),
      .dec    (dec_raw)
    );

`ifdef VDEC1_TAIL_FORCE_EN
    // In the tail the input bit is known to be 0, so odd states are pinned.
    assign lane_pm[L]  = (tail && LB[0]) ? PM_NEG : pm_raw;
    assign lane_dec[L] = (tail && LB[0]) ? 1'b0 : dec_raw;
`else
    assign lane_pm[L]  = pm_raw;
    assign lane_dec[L] = dec_raw;
`endif
  end

  // Metric banks: no reset. They are initialised on every accepted start.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      for (int i = 0; i < 256; i++) pm_a[i] <= (i == 0) ? '0 : PM_NEG;
    end else if (state == S_ACS) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (sel) pm_a[{word, 5'(i)}] <= lane_pm[i];
        else     pm_b[{word, 5'(i)}] <= lane_pm[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      ns_r    <= '0;
      step    <= '0;
      word    <= '0;
      llr_r   <= '0;
      sel     <= 1'b0;
      pt_we   <= 1'b0;
      pt_addr <= '0;
      pt_din  <= '0;
    end else begin
      done  <= 1'b0;
      // Decisions land in the RAM one cycle after their ACS word.
      pt_we <= (state == S_ACS);
      if (state == S_ACS) begin
        pt_addr <= {step, word};
        pt_din  <= lane_dec;
      end
      case (state)
        S_IDLE: if (start) begin
          ns_r  <= (codeblk_size > 6'd29) ? 6'd29 : codeblk_size;
          step  <= '0;
          sel   <= 1'b0;
          busy  <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: if (sym_valid) begin
          llr_r <= sym_llr;
          word  <= '0;
          state <= S_ACS;
        end
        S_ACS: begin
          word <= word + 3'd1;
          if (word == 3'd7) begin
            sel   <= ~sel;
            step  <= step + 6'd1;
            state <= (step == ns_r + 6'd7) ? S_FIN : S_WAIT;
          end
        end
        default: begin  // S_FIN: the last write drains this cycle
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vdec1_fwd.sv
// Randomised bench for vdec1_fwd. A behavioural trellis model predicts every
// traceback RAM write. A traceback over the captured RAM checks that the
// info bits decode correctly.
module tb_vdec1_fwd;
  localparam int LLR_W = 6;
  localparam int PM_W  = 14;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, sym_valid = 1'b0;
  logic [5:0]  codeblk_size = '0;
  logic [17:0] sym_llr = '0;
  logic        busy, done, sym_ready, pt_we;
  logic [8:0]  pt_addr;
  logic [31:0] pt_din;

  vdec1_fwd #(.LLR_W(LLR_W), .PM_W(PM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .codeblk_size(codeblk_size),
    .busy(busy), .done(done), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_llr(sym_llr), .pt_we(pt_we), .pt_addr(pt_addr), .pt_din(pt_din)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cycle = 0, wr_cnt = 0;
  bit chk_en = 1'b0;
  always @(posedge clk) cycle++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int G[3] = '{9'o557, 9'o663, 9'o711};
  int mpm[256];
  int mstep, mns;
  logic [40:0] exp_q[$];
  logic [31:0] ram [0:511];
  int sl[3][40];

  // h bit j = input bit j steps ago (j=0 newest); coded bit k.
  function automatic int cbit(input int k, input int h);
    int c = 0;
    for (int j = 0; j <= 8; j++) c ^= ((G[k] >> (8 - j)) & (h >> j) & 1);
    return c;
  endfunction

  function automatic int mbm(input int h, input int l[3]);
    int r = 0;
    for (int k = 0; k < 3; k++) r += cbit(k, h) ? -l[k] : l[k];
    return r;
  endfunction

  task automatic model_init(input int n);
    mns = (n > 29) ? 29 : n;
    mstep = 0;
    for (int s = 0; s < 256; s++) mpm[s] = (s == 0) ? 0 : -4096;
  endtask

  task automatic model_step(input int l[3]);
    int npm[256];
    logic [31:0] w[8];
    for (int s = 0; s < 256; s++) begin
      int m0, m1, d;
      m0 = mpm[s >> 1] + mbm(s, l);
      m1 = mpm[128 + (s >> 1)] + mbm(s | 256, l);
      d = (m1 > m0) ? 1 : 0;
      npm[s] = d ? m1 : m0;
`ifdef VDEC1_TAIL_FORCE_EN
      if (mstep >= mns && (s & 1)) begin npm[s] = -4096; d = 0; end
`endif
      w[s >> 5][s & 31] = d[0];
    end
    for (int k = 0; k < 8; k++) exp_q.push_back({9'(mstep * 8 + k), w[k]});
    mpm = npm;
    mstep++;
  endtask

  // Symbols for n info bits plus 8 zero tail bits, +/-amp, nflip sign errors.
  task automatic build_syms(input int n, input logic [63:0] bits, input int amp, input int nflip);
    int h = 0;
    for (int t = 0; t < n + 8; t++) begin
      h = ((h << 1) | ((t < n) ? int'(bits[t]) : 0)) & 511;
      for (int k = 0; k < 3; k++) sl[k][t] = cbit(k, h) ? -amp : amp;
    end
    for (int f = 0; f < nflip; f++) begin
      int k = $urandom_range(2);
      sl[k][3 + 9 * f] = -sl[k][3 + 9 * f];
    end
  endtask

  function automatic logic [63:0] traceback(input int nsteps, input int nbits);
    logic [63:0] r = '0;
    int st = 0;
    for (int t = nsteps - 1; t >= 0; t--) begin
      logic [31:0] wd;
      int d;
      wd = ram[t * 8 + (st >> 5)];
      d = int'(wd[st & 31]);
      if (t < nbits) r[t] = st[0];
      st = (d << 7) | (st >> 1);
    end
    return r;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en && pt_we) begin
      if (exp_q.size() == 0) chk("unexpected_write", 64'(pt_addr), 64'h1ff);
      else begin
        logic [40:0] e;
        e = exp_q.pop_front();
        chk("pt_addr", 64'(pt_addr), 64'(e[40:32]));
        chk("pt_din", 64'(pt_din), 64'(e[31:0]));
      end
      ram[pt_addr] = pt_din;
      wr_cnt++;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_sym_ready"}, 64'(sym_ready), 0);
    chk({tag, "_pt_we"}, 64'(pt_we), 0);
    chk({tag, "_pt_addr"}, 64'(pt_addr), 0);
    chk({tag, "_pt_din"}, 64'(pt_din), 0);
  endtask

  // One block. abort_step >= 0 asserts rst during word 3 of that step.
  task automatic run_block(input int n_in, input int vprob, input bit glitch,
                           input bit hold_done, input bit chk_lat, input int abort_step);
    int nsteps, idx = 0, cyc = 0, t_set, w0;
    nsteps = ((n_in > 29) ? 29 : n_in) + 8;
    if (!done) @(negedge clk);
    codeblk_size = 6'(n_in);
    start = 1'b1;
    t_set = cycle;
    w0 = wr_cnt;
    model_init(n_in);
    @(negedge clk);
    start = 1'b0;
    while (idx < nsteps && cyc < 5000) begin
      start = glitch && ($urandom_range(7) == 0);
      sym_valid = ($urandom_range(99) < vprob);
      sym_llr = {6'(sl[2][idx]), 6'(sl[1][idx]), 6'(sl[0][idx])};
      if (sym_valid && sym_ready) begin
        int l[3];
        l = '{sl[0][idx], sl[1][idx], sl[2][idx]};
        model_step(l);
        idx++;
        if (abort_step >= 0 && mstep == abort_step + 1) begin
          repeat (4) @(negedge clk);
          sym_valid = 1'b0;
          start = 1'b0;
          chk_en = 1'b0;
          rst = 1'b1;
          #1 chk_zero("abort");
          exp_q.delete();
          return;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    sym_valid = 1'b0;
    chk("symbols_accepted", 64'(idx), 64'(nsteps));
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 64'(done), 1);
    chk("busy_at_done", 64'(busy), 0);
    if (chk_lat) chk("latency", 64'(cycle - t_set), 64'(9 * nsteps + 2));
    chk("write_count", 64'(wr_cnt - w0), 64'(8 * nsteps));
    chk("queue_drained", 64'(exp_q.size()), 0);
    if (!hold_done) begin
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] bits;
    int n;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    chk_en = 1'b1;

    // All +31 symbols: the all-zero path, 37 steps, 296 writes.
    for (int t = 0; t < 37; t++) for (int k = 0; k < 3; k++) sl[k][t] = 31;
    run_block(29, 100, 0, 0, 1, -1);
    chk("pin_pm0_all31", 64'(mpm[0]), 64'(37 * 93));
    chk("decode_all31", traceback(37, 29), 0);
`ifdef VDEC1_TAIL_FORCE_EN
    for (int a = 29 * 8; a < 296; a++) chk("tail_odd_zero", 64'(ram[a] & 32'haaaaaaaa), 0);
`endif

    // Clean random block, then a back-to-back block with 4 sign errors.
    bits = {$urandom, $urandom} & 64'h1fffffff;
    build_syms(29, bits, 20, 0);
    run_block(29, 100, 0, 1, 1, -1);
    chk("pin_pm0_clean", 64'(mpm[0]), 64'(37 * 60));
    chk("decode_clean", traceback(37, 29), bits);

    bits = {$urandom, $urandom} & 64'h1fffffff;
    build_syms(29, bits, 20, 4);
    run_block(29, 100, 0, 0, 1, -1);
    chk("pin_pm0_flip4", 64'(mpm[0]), 64'(37 * 60 - 4 * 40));
    chk("decode_flip4", traceback(37, 29), bits);

    // Random sym_valid stalls, random N, start pulsed mid-run.
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(29);
      bits = {$urandom, $urandom} & ((64'd1 << n) - 1);
      build_syms(n, bits, 20, 0);
      run_block(n, 40, 1, 0, 0, -1);
      chk("decode_stall", traceback(n + 8, n), bits);
    end

    // N=0: tail only.
    build_syms(0, 0, 25, 0);
    run_block(0, 100, 0, 0, 1, -1);
    chk("decode_n0_state", traceback(8, 0), 0);

    // N=45 clamps to 29.
    bits = {$urandom, $urandom} & 64'h1fffffff;
    build_syms(29, bits, 20, 0);
    run_block(45, 100, 1, 0, 1, -1);
    chk("decode_n45", traceback(37, 29), bits);

    // Abort at step 10 word 3, then a normal block.
    bits = {$urandom, $urandom} & 64'h1fffffff;
    build_syms(29, bits, 20, 0);
    run_block(29, 100, 0, 0, 0, 10);
    repeat (2) @(negedge clk);
    chk_zero("abort_hold");
    rst = 1'b0;
    chk_en = 1'b1;
    bits = 64'(5'b10110);
    build_syms(5, bits, 20, 0);
    run_block(5, 100, 0, 0, 1, -1);
    chk("decode_after_abort", traceback(13, 5), bits);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
